rotate_key_sched: RTL

ROTATE_KEY_SCHED -- requirements
Module: rotate_key_sched

---
 rtl/rotate_key_sched_pkg.sv | 16 +
 rtl/rotate_key_sched_rotator.sv | 22 ++
 rtl/rotate_key_sched.sv | 97 +++++++++
 3 files changed

// File: rtl/rotate_key_sched_pkg.sv
// Shared types and helpers for the rotating round-key scheduler.
// Optional feature macro: KEYSCHED_RCON_XOR_EN (round-constant XOR).
package rotate_key_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Word width of the rotator for a given log2 width.
  function automatic int rotl_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/rotate_key_sched_rotator.sv
// Combinational circular left rotator, word width 2**N, rotate amount 0..2**N-1.
module leftShifter_para
  import rotate_key_sched_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [rotl_width(N)-1:0] word,
  input  logic [N-1:0]             amt,
  output logic [rotl_width(N)-1:0] rotated
);

  localparam int W = rotl_width(N);

  logic [2*W-1:0] doubled;

  // Bits shifted out of the top of the upper copy re-enter from the lower copy.
  always_comb begin
    doubled = {word, word} << amt;
    rotated = doubled[2*W-1:W];
  end

endmodule

// File: rtl/rotate_key_sched.sv
// Round-key scheduler: seed key rotated left by a fixed amount per accepted key.
// Optional feature macro: KEYSCHED_RCON_XOR_EN XORs (rk_idx+1) into each new key.
module rotate_key_sched
  import rotate_key_sched_pkg::*;
#(
  parameter int N      = 3,
  parameter int ROUNDS = 8,
  localparam int W     = rotl_width(N),
  localparam int IW    = $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  key_in,
  input  logic [N-1:0]  amt_in,
  output logic          busy,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [W-1:0]  rk_out,
  output logic [IW-1:0] rk_idx,
  output logic          done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(ROUNDS - 1);

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  key_reg;
  logic [N-1:0]  amt_reg;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  rotated;
  logic [W-1:0]  next_key;
  logic          xfer;
  logic          last;

  leftShifter_para #(.N(N)) u_rotl (
    .word    (key_reg),
    .amt     (amt_reg),
    .rotated (rotated)
  );

`ifdef KEYSCHED_RCON_XOR_EN
  logic [IW:0] idx_inc;
  assign idx_inc  = {1'b0, idx_reg} + 1'b1;
  assign next_key = rotated ^ W'(idx_inc);
`else
  assign next_key = rotated;
`endif

  assign xfer   = rk_valid & rk_ready;
  assign last   = (idx_reg == LAST_IDX);
  assign rk_out = key_reg;
  assign rk_idx = idx_reg;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rk_valid  = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready && last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      key_reg <= '0;
      amt_reg <= '0;
      idx_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        key_reg <= key_in;
        amt_reg <= amt_in;
        idx_reg <= '0;
      end else if (xfer && !last) begin
        key_reg <= next_key;
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

endmodule
